// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
// ----------------------------------------------------------------------------
// Main control FSM for a multi-cycle MIPS core. Steps each instruction through
// fetch (IF), decode (ID), execute (EX), memory (MEM) and write-back (WB) over
// a shared register-file/ALU/memory datapath. An exception state (XC) takes
// sticky interrupts and illegal opcodes into the kernel vector and saves the
// return address to $26.
//
// All outputs are combinational from the current state and the inputs.
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   Opcode       in   6  instruction[31:26] from IR, stable from ID to the end
//                        of the instruction
//   Funct        in   6  instruction[5:0] from IR
//   BranchTaken  in   1  ALU branch-condition result, valid in EX
//   MemReady     in   1  memory completes the current access this cycle
//   IRQ          in   1  level interrupt request
//   Kernel       in   1  PC[31]; high masks IRQ
//   PCWr         out  1  PC write strobe
//   PCSrc        out  3  next-PC select (PC+4, ConBA, JT, DataBusA, ILLOP, XADR)
//   IRWr         out  1  instruction-register load strobe
//   RegWr        out  1  register-file write strobe
//   RegDst       out  2  destination select (Rd, Rt, $31, $26)
//   MemToReg     out  2  write-data select (ALU, memory, PC)
//   MemRd        out  1  memory read request
//   MemWr        out  1  memory write request
//   State        out  3  current state, for debug
//   Retire       out  1  one-cycle pulse when an instruction completes
// ============================================================================
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       BranchTaken,
   input  logic       MemReady,
   input  logic       IRQ,
   input  logic       Kernel,
   output logic       PCWr,
   output logic [2:0] PCSrc,
   output logic       IRWr,
   output logic       RegWr,
   output logic [1:0] RegDst,
   output logic [1:0] MemToReg,
   output logic       MemRd,
   output logic       MemWr,
   output logic [2:0] State,
   output logic       Retire
);

   // ------------------------------------------------------------------------
   // Encodings
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_XC  = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_R,
      C_JR,
      C_JALR,
      C_J,
      C_JAL,
      C_BR,
      C_IMM,
      C_LW,
      C_SW,
      C_ILL
   } iclass_t;

   localparam logic [2:0] PC_PLUS4 = 3'b000;
   localparam logic [2:0] PC_CONBA = 3'b001;
   localparam logic [2:0] PC_JT    = 3'b010;
   localparam logic [2:0] PC_BUSA  = 3'b011;
   localparam logic [2:0] PC_ILLOP = 3'b100;
   localparam logic [2:0] PC_XADR  = 3'b101;

   localparam logic [1:0] DST_RD = 2'b00;
   localparam logic [1:0] DST_RT = 2'b01;
   localparam logic [1:0] DST_RA = 2'b10;
   localparam logic [1:0] DST_K0 = 2'b11;

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC  = 2'b10;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t  state_reg;
   state_t  state_next;
   logic    irq_pend_reg;
   // Remembers why we entered XC: 1 = interrupt, 0 = illegal opcode.
   logic    cause_irq_reg;

   iclass_t iclass;
   logic    irq_take;
   logic    irq_clear;

   // ------------------------------------------------------------------------
   // Instruction decode (pure function of the IR fields)
   // ------------------------------------------------------------------------
   always_comb begin
      iclass = C_ILL;
      if (Opcode == 6'h00) begin
         if (Funct == 6'h08)
            iclass = C_JR;
         else if (Funct == 6'h09)
            iclass = C_JALR;
         else
            iclass = C_R;
      end else if (Opcode == 6'h02) begin
         iclass = C_J;
      end else if (Opcode == 6'h03) begin
         iclass = C_JAL;
      end else if (Opcode[5:2] == 4'b0001) begin   // 04..07
         iclass = C_BR;
      end else if (Opcode[5:3] == 3'b001) begin    // 08..0F
         iclass = C_IMM;
      end else if (Opcode == 6'h23) begin
         iclass = C_LW;
      end else if (Opcode == 6'h2B) begin
         iclass = C_SW;
      end
   end

   // An interrupt is only taken at a decode boundary and only from user mode.
   assign irq_take  = irq_pend_reg & ~Kernel;
   // XC always lasts one cycle, so being in XC for an IRQ means leaving it now.
   assign irq_clear = (state_reg == S_XC) & cause_irq_reg;

   // ------------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_IF;
      end else begin
         state_reg <= state_next;
      end
   end

   // Sticky interrupt request. Clear has priority over a coincident set; a
   // still-asserted IRQ is simply picked up again on the following edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_pend_reg <= 1'b0;
      end else if (irq_clear) begin
         irq_pend_reg <= 1'b0;
      end else if (IRQ && !Kernel) begin
         irq_pend_reg <= 1'b1;
      end
   end

   // Cause is captured on every ID cycle; it is only consumed in XC, which is
   // reachable solely from ID.
   always_ff @(posedge clk) begin
      if (reset) begin
         cause_irq_reg <= 1'b0;
      end else if (state_reg == S_ID) begin
         cause_irq_reg <= irq_take;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      PCWr       = 1'b0;
      PCSrc      = PC_PLUS4;
      IRWr       = 1'b0;
      RegWr      = 1'b0;
      RegDst     = DST_RD;
      MemToReg   = WD_ALU;
      MemRd      = 1'b0;
      MemWr      = 1'b0;
      Retire     = 1'b0;

      case (state_reg)
         S_IF: begin
            MemRd = 1'b1;
            if (MemReady) begin
               IRWr       = 1'b1;
               PCWr       = 1'b1;
               PCSrc      = PC_PLUS4;
               state_next = S_ID;
            end
         end

         S_ID: begin
            if (irq_take) begin
               state_next = S_XC;
            end else if (iclass == C_ILL) begin
               state_next = S_XC;
            end else if (iclass == C_J) begin
               // Plain jump needs no ALU work, so it finishes in decode.
               PCWr       = 1'b1;
               PCSrc      = PC_JT;
               Retire     = 1'b1;
               state_next = S_IF;
            end else begin
               state_next = S_EX;
            end
         end

         S_EX: begin
            case (iclass)
               C_BR: begin
                  PCWr       = BranchTaken;
                  PCSrc      = PC_CONBA;
                  Retire     = 1'b1;
                  state_next = S_IF;
               end
               C_JR: begin
                  PCWr       = 1'b1;
                  PCSrc      = PC_BUSA;
                  Retire     = 1'b1;
                  state_next = S_IF;
               end
               C_JAL: begin
                  RegWr      = 1'b1;
                  RegDst     = DST_RA;
                  MemToReg   = WD_PC;
                  PCWr       = 1'b1;
                  PCSrc      = PC_JT;
                  Retire     = 1'b1;
                  state_next = S_IF;
               end
               C_JALR: begin
                  RegWr      = 1'b1;
                  RegDst     = DST_RD;
                  MemToReg   = WD_PC;
                  PCWr       = 1'b1;
                  PCSrc      = PC_BUSA;
                  Retire     = 1'b1;
                  state_next = S_IF;
               end
               C_LW, C_SW: begin
                  state_next = S_MEM;
               end
               C_R, C_IMM: begin
                  state_next = S_WB;
               end
               default: begin
                  // J and ILL never reach EX; recover to fetch quietly.
                  state_next = S_IF;
               end
            endcase
         end

         S_MEM: begin
            if (iclass == C_LW) begin
               MemRd = 1'b1;
               if (MemReady) begin
                  state_next = S_WB;
               end
            end else if (iclass == C_SW) begin
               MemWr = 1'b1;
               if (MemReady) begin
                  Retire     = 1'b1;
                  state_next = S_IF;
               end
            end else begin
               state_next = S_IF;
            end
         end

         S_WB: begin
            RegWr      = 1'b1;
            Retire     = 1'b1;
            state_next = S_IF;
            case (iclass)
               C_IMM: begin
                  RegDst   = DST_RT;
                  MemToReg = WD_ALU;
               end
               C_LW: begin
                  RegDst   = DST_RT;
                  MemToReg = WD_MEM;
               end
               default: begin
                  RegDst   = DST_RD;
                  MemToReg = WD_ALU;
               end
            endcase
         end

         S_XC: begin
            // PC was already incremented in IF, so PC is the return address.
            RegWr      = 1'b1;
            RegDst     = DST_K0;
            MemToReg   = WD_PC;
            PCWr       = 1'b1;
            PCSrc      = cause_irq_reg ? PC_ILLOP : PC_XADR;
            state_next = S_IF;
         end

         default: begin
            state_next = S_IF;
         end
      endcase

      // Reset silences every strobe, including one from an abandoned access.
      if (reset) begin
         state_next = S_IF;
         PCWr       = 1'b0;
         PCSrc      = PC_PLUS4;
         IRWr       = 1'b0;
         RegWr      = 1'b0;
         RegDst     = DST_RD;
         MemToReg   = WD_ALU;
         MemRd      = 1'b0;
         MemWr      = 1'b0;
         Retire     = 1'b0;
      end
   end

   assign State = reset ? 3'd0 : state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Each task starts mid-cycle with the
// DUT in IF, drives one instruction and compares the full output vector.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       BranchTaken;
   logic       MemReady;
   logic       IRQ;
   logic       Kernel;
   logic       PCWr;
   logic [2:0] PCSrc;
   logic       IRWr;
   logic       RegWr;
   logic [1:0] RegDst;
   logic [1:0] MemToReg;
   logic       MemRd;
   logic       MemWr;
   logic [2:0] State;
   logic       Retire;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_v;
   logic [15:0] outs;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
      .BranchTaken(BranchTaken), .MemReady(MemReady), .IRQ(IRQ), .Kernel(Kernel),
      .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .RegWr(RegWr), .RegDst(RegDst),
      .MemToReg(MemToReg), .MemRd(MemRd), .MemWr(MemWr), .State(State), .Retire(Retire)
   );

   always #5 clk = ~clk;

   // {State, PCWr, PCSrc, IRWr, RegWr, RegDst, MemToReg, MemRd, MemWr, Retire}
   assign outs = {State, PCWr, PCSrc, IRWr, RegWr, RegDst, MemToReg, MemRd, MemWr, Retire};

   function automatic logic [15:0] e(input logic [2:0] st, input logic pcwr,
                                     input logic [2:0] pcsrc, input logic irwr,
                                     input logic regwr, input logic [1:0] dst,
                                     input logic [1:0] m2r, input logic mrd,
                                     input logic mwr, input logic ret);
      return {st, pcwr, pcsrc, irwr, regwr, dst, m2r, mrd, mwr, ret};
   endfunction

   // Advance one clock; leaves us 1 time unit past the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Settle combinational outputs before comparing.
   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; MemReady = 1'b1; IRQ = 1'b0; Kernel = 1'b0;
      Opcode = 6'h00; Funct = 6'h20; BranchTaken = 1'b0;
      settle();
      for (int i = 0; i < 3; i++) begin
         exp_v = 16'h0000;
         if (outs !== exp_v) begin errors++; $display("FAIL reset_hold[%0d]: got %h exp %h", i, outs, exp_v); end
         checks++;
         cyc();
      end
      reset = 1'b0;
      settle();
      exp_v = e(3'd0, 1, 3'b000, 1, 0, 2'b00, 2'b00, 1, 0, 0);
      if (outs !== exp_v) begin errors++; $display("FAIL reset_release_if: got %h exp %h", outs, exp_v); end
      checks++;
      cyc();
      $display("reset: released, now in ID");
      // Finish this fetched R-type so the next task starts in IF.
      cyc(); cyc(); cyc();
   endtask

   task automatic test_rtype();
      Opcode = 6'h00; Funct = 6'h20; MemReady = 1'b1; settle();
      exp_v = e(3'd0, 1, 3'b000, 1, 0, 2'b00, 2'b00, 1, 0, 0);
      if (outs !== exp_v) begin errors++; $display("FAIL rtype_if: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      exp_v = e(3'd1, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      if (outs !== exp_v) begin errors++; $display("FAIL rtype_id: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      exp_v = e(3'd2, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      if (outs !== exp_v) begin errors++; $display("FAIL rtype_ex: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      exp_v = e(3'd4, 0, 3'b000, 0, 1, 2'b00, 2'b00, 0, 0, 1);
      if (outs !== exp_v) begin errors++; $display("FAIL rtype_wb: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      if (State !== 3'd0) begin errors++; $display("FAIL rtype_back_to_if: got %0d exp 0", State); end
      checks++;
      $display("rtype: add completed in 4 cycles");
   endtask

   task automatic test_lw_sw();
      // LW with two wait cycles in MEM
      Opcode = 6'h23; Funct = 6'h00; MemReady = 1'b1; settle();
      cyc(); cyc();                          // IF -> ID -> EX
      MemReady = 1'b0; cyc();                // EX -> MEM
      for (int i = 0; i < 3; i++) begin
         MemReady = (i == 2); settle();
         exp_v = e(3'd3, 0, 3'b000, 0, 0, 2'b00, 2'b00, 1, 0, 0);
         if (outs !== exp_v) begin errors++; $display("FAIL lw_mem[%0d]: got %h exp %h", i, outs, exp_v); end
         checks++; cyc();
      end
      exp_v = e(3'd4, 0, 3'b000, 0, 1, 2'b01, 2'b01, 0, 0, 1);
      if (outs !== exp_v) begin errors++; $display("FAIL lw_wb: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      $display("lw: 3 MEM cycles then WB");
      // SW, with a one-cycle fetch stall
      Opcode = 6'h2B; MemReady = 1'b0; settle();
      exp_v = e(3'd0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 1, 0, 0);
      if (outs !== exp_v) begin errors++; $display("FAIL if_stall: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      MemReady = 1'b1; cyc(); cyc();         // IF -> ID -> EX
      MemReady = 1'b0; cyc();                // EX -> MEM
      exp_v = e(3'd3, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 1, 0);
      if (outs !== exp_v) begin errors++; $display("FAIL sw_mem_wait: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      MemReady = 1'b1; settle();
      exp_v = e(3'd3, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 1, 1);
      if (outs !== exp_v) begin errors++; $display("FAIL sw_mem_done: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      if (State !== 3'd0) begin errors++; $display("FAIL sw_back_to_if: got %0d exp 0", State); end
      checks++;
      $display("sw: store retired from MEM");
   endtask

   task automatic test_branch();
      for (int t = 1; t >= 0; t--) begin
         Opcode = 6'h04; MemReady = 1'b1; BranchTaken = t[0];
         cyc(); cyc(); settle();             // IF -> ID -> EX
         exp_v = e(3'd2, t[0], 3'b001, 0, 0, 2'b00, 2'b00, 0, 0, 1);
         if (outs !== exp_v) begin errors++; $display("FAIL beq_ex_taken%0d: got %h exp %h", t, outs, exp_v); end
         checks++; cyc();
         $display("beq: taken=%0d", t);
      end
      BranchTaken = 1'b0;
   endtask

   task automatic test_jumps();
      // J finishes in ID
      Opcode = 6'h02; cyc(); settle();
      exp_v = e(3'd1, 1, 3'b010, 0, 0, 2'b00, 2'b00, 0, 0, 1);
      if (outs !== exp_v) begin errors++; $display("FAIL j_id: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      // JAL
      Opcode = 6'h03; cyc(); cyc(); settle();
      exp_v = e(3'd2, 1, 3'b010, 0, 1, 2'b10, 2'b10, 0, 0, 1);
      if (outs !== exp_v) begin errors++; $display("FAIL jal_ex: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      // JALR
      Opcode = 6'h00; Funct = 6'h09; cyc(); cyc(); settle();
      exp_v = e(3'd2, 1, 3'b011, 0, 1, 2'b00, 2'b10, 0, 0, 1);
      if (outs !== exp_v) begin errors++; $display("FAIL jalr_ex: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      // JR
      Funct = 6'h08; cyc(); cyc(); settle();
      exp_v = e(3'd2, 1, 3'b011, 0, 0, 2'b00, 2'b00, 0, 0, 1);
      if (outs !== exp_v) begin errors++; $display("FAIL jr_ex: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      // IMM (addi) writes Rt
      Opcode = 6'h08; Funct = 6'h00; cyc(); cyc(); cyc(); settle();
      exp_v = e(3'd4, 0, 3'b000, 0, 1, 2'b01, 2'b00, 0, 0, 1);
      if (outs !== exp_v) begin errors++; $display("FAIL imm_wb: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      $display("jumps: j/jal/jalr/jr/addi done");
   endtask

   task automatic test_exceptions();
      // LW with IRQ pulsed during MEM; the LW must still complete.
      Opcode = 6'h23; Funct = 6'h00; MemReady = 1'b1;
      cyc(); cyc(); cyc();                   // IF -> ID -> EX -> MEM
      MemReady = 1'b0; IRQ = 1'b1; cyc();    // pend set on this edge
      IRQ = 1'b0; MemReady = 1'b1; settle();
      exp_v = e(3'd3, 0, 3'b000, 0, 0, 2'b00, 2'b00, 1, 0, 0);
      if (outs !== exp_v) begin errors++; $display("FAIL irq_mem_not_interrupted: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      exp_v = e(3'd4, 0, 3'b000, 0, 1, 2'b01, 2'b01, 0, 0, 1);
      if (outs !== exp_v) begin errors++; $display("FAIL irq_lw_wb: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      // Next instruction is illegal too: IRQ must win.
      Opcode = 6'h3F; cyc(); settle();
      exp_v = e(3'd1, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0);
      if (outs !== exp_v) begin errors++; $display("FAIL irq_id: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      exp_v = e(3'd5, 1, 3'b100, 0, 1, 2'b11, 2'b10, 0, 0, 0);
      if (outs !== exp_v) begin errors++; $display("FAIL irq_xc: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      // Pending cleared; the illegal opcode now traps on its own.
      cyc(); cyc(); settle();
      exp_v = e(3'd5, 1, 3'b101, 0, 1, 2'b11, 2'b10, 0, 0, 0);
      if (outs !== exp_v) begin errors++; $display("FAIL ill_xc: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      $display("exceptions: irq then illop trapped");
      // Kernel mode masks IRQ.
      Kernel = 1'b1; IRQ = 1'b1; Opcode = 6'h00; Funct = 6'h20;
      cyc(); cyc(); settle();
      if (State !== 3'd2) begin errors++; $display("FAIL kernel_masks_irq_id: got %0d exp 2", State); end
      checks++; cyc();
      IRQ = 1'b0; cyc();                     // WB -> IF
      Kernel = 1'b0; cyc(); cyc(); settle();
      if (State !== 3'd2) begin errors++; $display("FAIL kernel_irq_not_latched: got %0d exp 2", State); end
      checks++; cyc(); cyc();
      $display("exceptions: kernel-mode irq ignored");
   endtask

   task automatic test_reset_mid();
      Opcode = 6'h2B; MemReady = 1'b1;
      cyc(); cyc(); cyc();                   // now in MEM with MemReady high
      reset = 1'b1; settle();
      exp_v = 16'h0000;
      if (outs !== exp_v) begin errors++; $display("FAIL reset_mid_mem: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      reset = 1'b0; settle();
      exp_v = e(3'd0, 1, 3'b000, 1, 0, 2'b00, 2'b00, 1, 0, 0);
      if (outs !== exp_v) begin errors++; $display("FAIL reset_mid_restart: got %h exp %h", outs, exp_v); end
      checks++; cyc();
      $display("reset_mid: store abandoned, refetching");
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_sw();
      test_branch();
      test_jumps();
      test_exceptions();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
